// File: rtl/accumulator_stage_pkg.sv
// Shared types and width helpers for the accumulator stage.
package accumulator_stage_pkg;

  typedef enum logic {StIdle, StAccum} state_e;

  function automatic int unsigned acc_width(int unsigned in_w, int unsigned len);
    return in_w + $clog2(len) + 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  function automatic int unsigned scale_shift(int unsigned in_frac, int unsigned out_frac);
    return (in_frac >= out_frac) ? (in_frac - out_frac) : (out_frac - in_frac);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/accumulator_stage_if.sv
// Product-in / result-out bundle between the array controller and the accumulator stage.
interface accumulator_stage_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                 stall;
  logic                 clear;
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 busy;
  logic                 overflow;

  modport master (
    output stall, clear, in_valid, in_data,
    input  out_data, out_valid, busy, overflow
  );

  modport slave (
    input  stall, clear, in_valid, in_data,
    output out_data, out_valid, busy, overflow
  );
endinterface

// File: rtl/accumulator_stage_sat_narrow.sv
// Rescales a full-precision sum to the output format, then clamps (SAT_EN) or wraps.
module accumulator_stage_sat_narrow
  import accumulator_stage_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned IN_FRAC   = 10,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned OUT_FRAC  = 10,
  parameter bit          SAT_EN    = 1'b0
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] result,
  output logic                        clipped
);

  localparam int unsigned Shift      = scale_shift(IN_FRAC, OUT_FRAC);
  localparam bit          RightShift = (IN_FRAC >= OUT_FRAC);
  localparam int unsigned Wide       = max_u(ACC_WIDTH + Shift, OUT_WIDTH + 1);

  logic signed [Wide-1:0] ext, scaled, max_v, min_v;

  always_comb begin
    ext    = Wide'(sum);
    scaled = RightShift ? (ext >>> Shift) : (ext <<< Shift);
    max_v  = '0;
    max_v[OUT_WIDTH-2:0] = '1;
    min_v  = ~max_v;
    clipped = SAT_EN && ((scaled > max_v) || (scaled < min_v));
    if (clipped) begin
      result = scaled[Wide-1] ? min_v[OUT_WIDTH-1:0] : max_v[OUT_WIDTH-1:0];
    end else begin
      result = scaled[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/accumulator_stage.sv
// Sums ACC_LEN valid products into one rescaled result with a one-cycle valid pulse.
// Define ACCUMULATOR_SAT_EN to clamp the result and enable the sticky overflow flag.
module accumulator_stage
  import accumulator_stage_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned IN_FRAC   = 10,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned OUT_FRAC  = 10,
  parameter int unsigned ACC_LEN   = 8
) (
  input logic               clk,
  input logic               reset,
  accumulator_stage_if.slave bus
);

  localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, ACC_LEN);
  localparam int unsigned CntW      = cnt_width(ACC_LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(ACC_LEN - 1);
`ifdef ACCUMULATOR_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d, narrowed;
  logic                   out_valid_q, out_valid_d;
  logic                   ovf_q, ovf_d;
  logic                   clipped, last, beat;

  assign sum  = acc_q + ACC_WIDTH'($signed(bus.in_data));
  assign last = (count_q == LastCnt);
  assign beat = bus.in_valid && !bus.stall && !bus.clear;

  accumulator_stage_sat_narrow #(
    .ACC_WIDTH(ACC_WIDTH),
    .IN_FRAC  (IN_FRAC),
    .OUT_WIDTH(OUT_WIDTH),
    .OUT_FRAC (OUT_FRAC),
    .SAT_EN   (SatEn)
  ) u_narrow (
    .sum    (sum),
    .result (narrowed),
    .clipped(clipped)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next state: IDLE means no partial sum; ACC_LEN==1 never leaves IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = StIdle;
    end else if (beat) begin
      unique case (state_q)
        StIdle:  if (!last) state_d = StAccum;
        StAccum: if (last)  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and output registers; clear wins over stall, stall freezes everything.
  always_comb begin
    count_d     = count_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (bus.clear) begin
      count_d     = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else if (!bus.stall) begin
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
        if (last) begin
          out_data_d  = narrowed;
          out_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = ovf_q | clipped;
        end else begin
          acc_d   = sum;
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.busy      = (count_q != '0);
    bus.out_data  = out_data_q;
    bus.out_valid = out_valid_q;
    bus.overflow  = ovf_q;
  end

endmodule
